// File: rtl/regex_multi.sv
// regex_multi: streaming matcher that tracks NUM_PAT runtime-programmable
// patterns in parallel. Each pattern position carries a symbol, a per-bit
// compare mask and a one-or-more repeat flag.
module regex_multi #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 8,
  parameter int NUM_PAT = 2,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int POS_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1,
  localparam int LEN_W  = $clog2(PAT_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i,
  input  logic [DATA_W-1:0] i_c,
  input  logic              cfg_we,
  input  logic              cfg_len_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [POS_W-1:0]  cfg_pos,
  input  logic [DATA_W-1:0] cfg_sym,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              cfg_rep,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              o,
  output logic [NUM_PAT-1:0] match,
  output logic [CNT_W-1:0]  match_pos,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam logic [31:0] NUM_PAT_U = NUM_PAT;
  localparam logic [31:0] PAT_LEN_U = PAT_LEN;

  // Symbol comparison honouring the don't-care mask (mask bit 1 = compare).
  function automatic logic sym_eq(input logic [DATA_W-1:0] c,
                                  input logic [DATA_W-1:0] s,
                                  input logic [DATA_W-1:0] m);
    return (((c ^ s) & m) == '0);
  endfunction

  logic [DATA_W-1:0]  sym_q  [NUM_PAT][PAT_LEN];
  logic [DATA_W-1:0]  sym_d  [NUM_PAT][PAT_LEN];
  logic [DATA_W-1:0]  mask_q [NUM_PAT][PAT_LEN];
  logic [DATA_W-1:0]  mask_d [NUM_PAT][PAT_LEN];
  logic [PAT_LEN-1:0] rep_q  [NUM_PAT];
  logic [PAT_LEN-1:0] rep_d  [NUM_PAT];
  logic [LEN_W-1:0]   len_q  [NUM_PAT];
  logic [LEN_W-1:0]   len_d  [NUM_PAT];
  logic [PAT_LEN-1:0] st_q   [NUM_PAT];
  logic [PAT_LEN-1:0] st_d   [NUM_PAT];
  logic [PAT_LEN-1:0] adv_s  [NUM_PAT];
  logic [NUM_PAT-1:0] acc_s;

  logic [CNT_W-1:0]   sym_idx_q, sym_idx_d;
  logic [CNT_W-1:0]   match_pos_q, match_pos_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [NUM_PAT-1:0] match_q, match_d;
  logic               o_q, o_d;

  logic [31:0] sel_ext_s, pos_ext_s, len_ext_s;
  logic        pos_we_s, len_we_s;

  // Qualify configuration writes; out-of-range writes are dropped entirely.
  always_comb begin
    sel_ext_s = {{(32-SEL_W){1'b0}}, cfg_sel};
    pos_ext_s = {{(32-POS_W){1'b0}}, cfg_pos};
    len_ext_s = {{(32-LEN_W){1'b0}}, cfg_len};
    pos_we_s  = cfg_we     && (sel_ext_s < NUM_PAT_U) && (pos_ext_s < PAT_LEN_U);
    len_we_s  = cfg_len_we && (sel_ext_s < NUM_PAT_U) && (len_ext_s <= PAT_LEN_U);
  end

  // Advance each pattern's state vector and detect acceptance using the old configuration.
  always_comb begin
    acc_s = '0;
    for (int p = 0; p < NUM_PAT; p++) begin
      adv_s[p] = st_q[p];
      if (i) begin
        adv_s[p][0] = sym_eq(i_c, sym_q[p][0], mask_q[p][0]);
        for (int k = 1; k < PAT_LEN; k++) begin
          adv_s[p][k] = sym_eq(i_c, sym_q[p][k], mask_q[p][k]) &
                        (st_q[p][k-1] | (rep_q[p][k] & st_q[p][k]));
        end
        for (int k = 0; k < PAT_LEN; k++) begin
          if (adv_s[p][k] && (len_q[p] == LEN_W'(k + 1))) begin
            acc_s[p] = 1'b1;
          end else begin
            acc_s[p] = acc_s[p];
          end
        end
      end else begin
        acc_s[p] = 1'b0;
      end
    end
  end

  // Next state for configuration, per-pattern state and the reporting counters.
  always_comb begin
    sym_d  = sym_q;
    mask_d = mask_q;
    rep_d  = rep_q;
    len_d  = len_q;
    for (int p = 0; p < NUM_PAT; p++) begin
      if ((pos_we_s || len_we_s) && (sel_ext_s == 32'(p))) begin
        st_d[p] = '0;
      end else begin
        st_d[p] = adv_s[p];
      end
    end
    if (pos_we_s) begin
      sym_d[cfg_sel][cfg_pos]  = cfg_sym;
      mask_d[cfg_sel][cfg_pos] = cfg_mask;
      rep_d[cfg_sel][cfg_pos]  = cfg_rep;
    end else begin
      sym_d = sym_q;
    end
    if (len_we_s) begin
      len_d[cfg_sel] = cfg_len;
    end else begin
      len_d = len_q;
    end

    sym_idx_d   = i ? (sym_idx_q + CNT_W'(1)) : sym_idx_q;
    match_d     = acc_s;
    o_d         = |acc_s;
    if (|acc_s) begin
      match_pos_d = sym_idx_d;
      match_cnt_d = (&match_cnt_q) ? match_cnt_q : (match_cnt_q + CNT_W'(1));
    end else begin
      match_pos_d = match_pos_q;
      match_cnt_d = match_cnt_q;
    end
  end

  // Register all state; reset clears configuration, state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q       <= '{default: '{default: '0}};
      mask_q      <= '{default: '{default: '0}};
      rep_q       <= '{default: '0};
      len_q       <= '{default: '0};
      st_q        <= '{default: '0};
      sym_idx_q   <= '0;
      match_pos_q <= '0;
      match_cnt_q <= '0;
      match_q     <= '0;
      o_q         <= 1'b0;
    end else begin
      sym_q       <= sym_d;
      mask_q      <= mask_d;
      rep_q       <= rep_d;
      len_q       <= len_d;
      st_q        <= st_d;
      sym_idx_q   <= sym_idx_d;
      match_pos_q <= match_pos_d;
      match_cnt_q <= match_cnt_d;
      match_q     <= match_d;
      o_q         <= o_d;
    end
  end

  assign o         = o_q;
  assign match     = match_q;
  assign match_pos = match_pos_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_regex_multi.sv
// Directed testbench for regex_multi (PAT_LEN=4, NUM_PAT=2) with a second
// CNT_W=2 instance sharing the inputs for counter saturation and wrap.
module tb_regex_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i = 1'b0;
  logic [7:0] i_c = 8'h00;
  logic       cfg_we = 1'b0;
  logic       cfg_len_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [1:0] cfg_pos = 2'd0;
  logic [7:0] cfg_sym = 8'h00;
  logic [7:0] cfg_mask = 8'h00;
  logic       cfg_rep = 1'b0;
  logic [2:0] cfg_len = 3'd0;

  logic        o, o2;
  logic [1:0]  match, match2;
  logic [15:0] match_pos, match_cnt;
  logic [1:0]  match_pos2, match_cnt2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  regex_multi #(.DATA_W(8), .PAT_LEN(4), .NUM_PAT(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c),
    .cfg_we(cfg_we), .cfg_len_we(cfg_len_we), .cfg_sel(cfg_sel), .cfg_pos(cfg_pos),
    .cfg_sym(cfg_sym), .cfg_mask(cfg_mask), .cfg_rep(cfg_rep), .cfg_len(cfg_len),
    .o(o), .match(match), .match_pos(match_pos), .match_cnt(match_cnt)
  );

  regex_multi #(.DATA_W(8), .PAT_LEN(4), .NUM_PAT(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c),
    .cfg_we(cfg_we), .cfg_len_we(cfg_len_we), .cfg_sel(cfg_sel), .cfg_pos(cfg_pos),
    .cfg_sym(cfg_sym), .cfg_mask(cfg_mask), .cfg_rep(cfg_rep), .cfg_len(cfg_len),
    .o(o2), .match(match2), .match_pos(match_pos2), .match_cnt(match_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    i = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0; reset = 1'b0;
  endtask

  task automatic sym(input logic [7:0] c);
    i = 1'b1; i_c = c;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic wr_pos(input logic sel, input logic [1:0] pos, input logic [7:0] s,
                        input logic [7:0] m, input logic rep);
    cfg_we = 1'b1; cfg_sel = sel; cfg_pos = pos; cfg_sym = s; cfg_mask = m; cfg_rep = rep;
    tick();
  endtask

  task automatic wr_len(input logic sel, input logic [2:0] len);
    cfg_len_we = 1'b1; cfg_sel = sel; cfg_len = len;
    tick();
  endtask

  task automatic load2(input logic sel, input logic [7:0] c0, input logic [7:0] c1);
    wr_pos(sel, 2'd0, c0, 8'hFF, 1'b0);
    wr_pos(sel, 2'd1, c1, 8'hFF, 1'b0);
    wr_len(sel, 3'd2);
  endtask

  task automatic test_reset();
    reset = 1'b1; i = 1'b1; i_c = 8'h61;
    tick();
    checks++; if (o !== 1'b0) begin fails++; $display("FAIL reset_o got %b want 0", o); end
    checks++; if (match !== 2'b00) begin fails++; $display("FAIL reset_match got %b want 00", match); end
    checks++; if (match_pos !== 16'd0) begin fails++; $display("FAIL reset_pos got %0d want 0", match_pos); end
    checks++; if (match_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    checks++; if (match_cnt2 !== 2'd0) begin fails++; $display("FAIL reset_cnt2 got %0d want 0", match_cnt2); end
    // the symbol presented during reset must not have advanced the index
    wr_pos(1'b0, 2'd0, 8'h61, 8'hFF, 1'b0);
    wr_len(1'b0, 3'd1);
    sym(8'h61);
    checks++; if (match_pos !== 16'd1) begin fails++; $display("FAIL reset_idx got %0d want 1", match_pos); end
  endtask

  task automatic test_basic();
    logic [7:0] s [4];
    logic       e [4];
    s = '{8'h78, 8'h61, 8'h61, 8'h62};
    e = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    load2(1'b0, 8'h61, 8'h62);
    for (int n = 0; n < 4; n++) begin
      sym(s[n]);
      checks++; if (match !== {1'b0, e[n]}) begin fails++; $display("FAIL basic_match[%0d] got %b want %b", n, match, {1'b0, e[n]}); end
      checks++; if (o !== e[n]) begin fails++; $display("FAIL basic_o[%0d] got %b want %b", n, o, e[n]); end
    end
    checks++; if (match_pos !== 16'd4) begin fails++; $display("FAIL basic_pos got %0d want 4", match_pos); end
    checks++; if (match_cnt !== 16'd1) begin fails++; $display("FAIL basic_cnt got %0d want 1", match_cnt); end
    tick();
    checks++; if (o !== 1'b0) begin fails++; $display("FAIL basic_idle_o got %b want 0", o); end
    checks++; if (match_pos !== 16'd4) begin fails++; $display("FAIL basic_hold_pos got %0d want 4", match_pos); end
  endtask

  task automatic test_repeat();
    logic [7:0] s [7];
    logic [1:0] e [7];
    s = '{8'h61, 8'h62, 8'h62, 8'h62, 8'h63, 8'h61, 8'h63};
    e = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    do_reset();
    wr_pos(1'b1, 2'd0, 8'h61, 8'hFF, 1'b0);
    wr_pos(1'b1, 2'd1, 8'h62, 8'hFF, 1'b1);
    wr_pos(1'b1, 2'd2, 8'h63, 8'hFF, 1'b0);
    wr_len(1'b1, 3'd3);
    for (int n = 0; n < 7; n++) begin
      sym(s[n]);
      checks++; if (match !== e[n]) begin fails++; $display("FAIL repeat_match[%0d] got %b want %b", n, match, e[n]); end
    end
    checks++; if (match_pos !== 16'd5) begin fails++; $display("FAIL repeat_pos got %0d want 5", match_pos); end
    checks++; if (match_cnt !== 16'd1) begin fails++; $display("FAIL repeat_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_mask();
    logic [7:0] s [3];
    logic       e [3];
    s = '{8'h4A, 8'h51, 8'h4F};
    e = '{1'b1, 1'b0, 1'b1};
    do_reset();
    wr_pos(1'b0, 2'd0, 8'h40, 8'hF0, 1'b0);
    wr_len(1'b0, 3'd1);
    for (int n = 0; n < 3; n++) begin
      sym(s[n]);
      checks++; if (o !== e[n]) begin fails++; $display("FAIL mask_o[%0d] got %b want %b", n, o, e[n]); end
    end
    checks++; if (match_cnt !== 16'd2) begin fails++; $display("FAIL mask_cnt got %0d want 2", match_cnt); end
    checks++; if (match_pos !== 16'd3) begin fails++; $display("FAIL mask_pos got %0d want 3", match_pos); end
  endtask

  task automatic test_gaps();
    logic e [7];
    e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    load2(1'b0, 8'h61, 8'h61);
    for (int n = 0; n < 7; n++) begin
      if (n % 2 == 0) sym(8'h61);
      else tick();
      checks++; if (o !== e[n]) begin fails++; $display("FAIL gaps_o[%0d] got %b want %b", n, o, e[n]); end
    end
    checks++; if (match_pos !== 16'd4) begin fails++; $display("FAIL gaps_pos got %0d want 4", match_pos); end
    checks++; if (match_cnt !== 16'd3) begin fails++; $display("FAIL gaps_cnt got %0d want 3", match_cnt); end
    load2(1'b1, 8'h61, 8'h61);
    sym(8'h61);
    checks++; if (match !== 2'b01) begin fails++; $display("FAIL dual_first got %b want 01", match); end
    sym(8'h61);
    checks++; if (match !== 2'b11) begin fails++; $display("FAIL dual_match got %b want 11", match); end
    checks++; if (match_cnt !== 16'd5) begin fails++; $display("FAIL dual_cnt got %0d want 5", match_cnt); end
    checks++; if (match_pos !== 16'd6) begin fails++; $display("FAIL dual_pos got %0d want 6", match_pos); end
  endtask

  task automatic test_saturate();
    logic [1:0] ep [5];
    logic [1:0] ec [5];
    ep = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ec = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    wr_pos(1'b0, 2'd0, 8'h61, 8'hFF, 1'b0);
    wr_len(1'b0, 3'd1);
    for (int n = 0; n < 5; n++) begin
      sym(8'h61);
      checks++; if (match_pos2 !== ep[n]) begin fails++; $display("FAIL sat_pos[%0d] got %0d want %0d", n, match_pos2, ep[n]); end
      checks++; if (match_cnt2 !== ec[n]) begin fails++; $display("FAIL sat_cnt[%0d] got %0d want %0d", n, match_cnt2, ec[n]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load2(1'b0, 8'h61, 8'h62);
    sym(8'h61);
    do_reset();
    sym(8'h62);
    checks++; if (match !== 2'b00) begin fails++; $display("FAIL rstmid_match got %b want 00", match); end
    checks++; if (o !== 1'b0) begin fails++; $display("FAIL rstmid_o got %b want 0", o); end
    checks++; if (match_pos !== 16'd0) begin fails++; $display("FAIL rstmid_pos got %0d want 0", match_pos); end
    checks++; if (match_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_cnt got %0d want 0", match_cnt); end
    sym(8'h61);
    sym(8'h62);
    checks++; if (match !== 2'b00) begin fails++; $display("FAIL rstmid_len0 got %b want 00", match); end
  endtask

  task automatic test_reconfig();
    do_reset();
    load2(1'b0, 8'h61, 8'h62);
    sym(8'h61);
    wr_pos(1'b0, 2'd0, 8'h61, 8'hFF, 1'b0);
    sym(8'h62);
    checks++; if (match !== 2'b00) begin fails++; $display("FAIL reconf_cleared got %b want 00", match); end
    sym(8'h61);
    sym(8'h62);
    checks++; if (match !== 2'b01) begin fails++; $display("FAIL reconf_after got %b want 01", match); end
    checks++; if (match_pos !== 16'd4) begin fails++; $display("FAIL reconf_pos got %0d want 4", match_pos); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    load2(1'b0, 8'h61, 8'h62);
    sym(8'h61);
    // rewrite position 1 with the same symbol while 'b' arrives
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_pos = 2'd1; cfg_sym = 8'h62; cfg_mask = 8'hFF; cfg_rep = 1'b0;
    sym(8'h62);
    checks++; if (match !== 2'b01) begin fails++; $display("FAIL same_match got %b want 01", match); end
    checks++; if (match_pos !== 16'd2) begin fails++; $display("FAIL same_pos got %0d want 2", match_pos); end
    sym(8'h62);
    checks++; if (match !== 2'b00) begin fails++; $display("FAIL same_clear got %b want 00", match); end
    // out-of-range length write is ignored, partial match survives
    sym(8'h61);
    wr_len(1'b0, 3'd5);
    sym(8'h62);
    checks++; if (match !== 2'b01) begin fails++; $display("FAIL bad_len got %b want 01", match); end
    checks++; if (match_pos !== 16'd5) begin fails++; $display("FAIL bad_len_pos got %0d want 5", match_pos); end
    // simultaneous position and length write on one pattern
    cfg_we = 1'b1; cfg_pos = 2'd0; cfg_sym = 8'h78; cfg_mask = 8'hFF; cfg_rep = 1'b0;
    cfg_len_we = 1'b1; cfg_sel = 1'b0; cfg_len = 3'd1;
    tick();
    sym(8'h78);
    checks++; if (match !== 2'b01) begin fails++; $display("FAIL both_we got %b want 01", match); end
    checks++; if (match_cnt !== 16'd3) begin fails++; $display("FAIL both_we_cnt got %0d want 3", match_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_mask();
    test_gaps();
    test_saturate();
    test_reset_mid();
    test_reconfig();
    test_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regex_multi.md
# regex_multi

Parametrised streaming pattern matcher, the successor to the single-bit `regex` block. It accepts one DATA_W-bit symbol per valid cycle and tracks NUM_PAT runtime-programmable patterns in parallel. Each pattern has up to PAT_LEN positions, per-bit don't-care masks and a per-position one-or-more repeat. It reports per-pattern matches, the stream index of the matching symbol, and a saturating match counter. It sits between the symbol source and the match-reporting logic.

## Interface
- DATA_W, 8, symbol width
- PAT_LEN, 8, max positions per pattern (≥1)
- NUM_PAT, 2, number of independent patterns (≥1)
- CNT_W, 16, width of position and match counters
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and configuration
- i  in  1  symbol valid
- i_c  in  DATA_W  symbol
- cfg_we  in  1  write one pattern position
- cfg_len_we  in  1  write pattern length
- cfg_sel  in  max(1,clog2(NUM_PAT))  pattern select
- cfg_pos  in  max(1,clog2(PAT_LEN))  position select
- cfg_sym  in  DATA_W  expected symbol
- cfg_mask  in  DATA_W  1 = compare bit, 0 = don't care
- cfg_rep  in  1  position may repeat (one-or-more)
- cfg_len  in  clog2(PAT_LEN+1)  pattern length; 0 = disabled
- o  out  1  OR of match
- match  out  NUM_PAT  per-pattern match pulse
- match_pos  out  CNT_W  index of last accepting symbol
- match_cnt  out  CNT_W  count of cycles with any match, saturating

## Operation
- Per pattern p, a state vector s[0..PAT_LEN-1]. s[k]=1 means positions 0..k matched, ending at the last accepted symbol.
- eq[k] = (((i_c ^ sym[k]) & mask[k]) == 0).
- On i=1: s'[0]=eq[0], because matching is unanchored and may start at any symbol. For k≥1, s'[k] = eq[k] & (s[k-1] | (rep[k] & s[k])). rep[0] has no effect.
- Accept when s'[len-1]=1 and len≠0.
- State is not cleared on accept, so overlapping matches are all reported.
- On i=0: state, sym_idx, match_pos and match_cnt hold; match and o are 0.
- sym_idx: internal CNT_W counter, incremented on every i=1. The first symbol after reset has index 1. The counter wraps from all-ones to 0.
- On accept by any pattern:
  - match_pos ← index of the accepting symbol.
  - match_cnt increments by 1 per cycle, not per pattern, and saturates at all-ones.
- Configuration:
  - cfg_we writes sym/mask/rep at (cfg_sel, cfg_pos).
  - cfg_len_we writes len.
  - Either write clears s of the selected pattern only.
  - Writes with cfg_sel ≥ NUM_PAT, cfg_pos ≥ PAT_LEN or cfg_len > PAT_LEN are ignored entirely, including the state clear.
- Configuration write in the same cycle as i=1: the symbol is evaluated with the old configuration and its match is reported. The state clear then overrides the state update for that pattern.
- cfg_we and cfg_len_we together on the same pattern: both take effect.

## Timing
- Reset values: o=0, match=0, match_pos=0, match_cnt=0, sym_idx=0, all s=0, all len=0, all sym/mask/rep=0.
- Latency: a symbol sampled at edge N produces match/o high for exactly the cycle after edge N, i.e. registered at edge N.
- match_pos and match_cnt update at the same edge as match.
- Configuration takes effect for symbols sampled from the next edge onward.
- Reset asserted mid-stream wins over everything in that cycle. The symbol presented during reset is discarded and does not advance sym_idx.
- No backpressure: every i=1 cycle is consumed.

## Test plan
All scenarios use DATA_W=8, PAT_LEN=4, NUM_PAT=2, CNT_W=16.
- Load p0 = "ab" (0x61,0x62, mask 0xFF, len 2); stream "xaab" → match[0]=1 and o=1 only in the cycle after 'b'; match_pos=4, match_cnt=1.
- Load p1 = "ab+c" (rep[1]=1, len 3); stream "abbbc" then "ac" → one match[1] with match_pos=5; no match on "ac".
- Mask: p0 = {0x40, mask 0xF0}, len 1; stream 0x4A, 0x51, 0x4F → match at indices 1 and 3 only; match_cnt=2.
- Gaps and overlap:
  - p0 = "aa"; stream "aaaa" with i=0 cycles between symbols → matches at indices 2, 3, 4, with o=0 in the gap cycles; match_cnt=3.
  - With p1 also set to "aa", match=2'b11 and match_cnt still increments by 1 per cycle.
- Saturation and wrap: with CNT_W=2 and p0 = "a" len 1, stream 5×'a' → match_cnt stops at 3; match_pos sequence is 1, 2, 3, 0, 1.
- Reset and reconfiguration mid-pattern:
  - p0 = "ab", stream 'a', assert reset for 1 cycle, then 'b' → no match; all outputs 0; len=0.
  - Separately, 'a' followed by a cfg_we to p0 in the next cycle, then 'b' → no match, because the partial match was cleared.
